// File: rtl/mode_decoder_if.sv
// Load/store decode bus: request fields from the pipeline, decoded lane info back.
interface mode_decoder_if;
  logic [1:0] func3_2;
  logic       in_valid;
  logic [1:0] addr_lo;
  logic [2:0] mode;
  logic       out_valid;
  logic [3:0] byte_en;
  logic       misaligned;
  logic       illegal;

  modport master (
    output func3_2, in_valid, addr_lo,
    input  mode, out_valid, byte_en, misaligned, illegal
  );

  modport slave (
    input  func3_2, in_valid, addr_lo,
    output mode, out_valid, byte_en, misaligned, illegal
  );
endinterface

// File: rtl/mode_decoder.sv
// RV32 load/store size decode: combinational one-hot mode plus registered
// byte-lane enables with misalignment and illegal-size flags.
module mode_decoder (
  input  logic          clk,
  input  logic          rst,
  mode_decoder_if.slave bus
);
  logic       out_valid_q;
  logic [3:0] byte_en_d, byte_en_q;
  logic       misaligned_d, misaligned_q;
  logic       illegal_d, illegal_q;

  always_comb begin
    unique case (bus.func3_2)
      2'b00:   bus.mode = 3'b001;
      2'b01:   bus.mode = 3'b010;
      2'b10:   bus.mode = 3'b100;
      default: bus.mode = 3'b000;
    endcase
  end

  // Invalid cycles register all-zero so stale lanes never leak downstream.
  always_comb begin
    byte_en_d    = 4'b0000;
    misaligned_d = 1'b0;
    illegal_d    = 1'b0;
    if (bus.in_valid) begin
      unique case (bus.func3_2)
        2'b00: byte_en_d = 4'b0001 << bus.addr_lo;
        2'b01: begin
          if (bus.addr_lo[0]) misaligned_d = 1'b1;
          else                byte_en_d    = 4'b0011 << bus.addr_lo;
        end
        2'b10: begin
          if (bus.addr_lo != 2'b00) misaligned_d = 1'b1;
          else                      byte_en_d    = 4'b1111;
        end
        default: illegal_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      byte_en_q    <= 4'b0000;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      out_valid_q  <= bus.in_valid;
      byte_en_q    <= byte_en_d;
      misaligned_q <= misaligned_d;
      illegal_q    <= illegal_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.byte_en    = byte_en_q;
  assign bus.misaligned = misaligned_q;
  assign bus.illegal    = illegal_q;
endmodule

// File: tb/tb_mode_decoder.sv
// Bench for mode_decoder: directed corner tables, random traffic and a
// mid-stream reset, all checked against an arithmetic size/alignment model.
module tb_mode_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   clk_run = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [6:0] pend = '0;  // {out_valid, byte_en, misaligned, illegal}

  mode_decoder_if bus ();
  mode_decoder dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 if (clk_run) clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] mode_ref(input int f);
    return (f == 3) ? 3'd0 : 3'(1 << f);
  endfunction

  // Access size in bytes is 2**f; natural alignment means addr is a multiple of it.
  function automatic logic [6:0] regs_ref(input bit v, input int f, input int a);
    int size, be;
    if (!v) return 7'd0;
    if (f == 3) return {1'b1, 4'd0, 1'b0, 1'b1};
    size = 1 << f;
    if ((a % size) != 0) return {1'b1, 4'd0, 1'b1, 1'b0};
    be = ((1 << size) - 1) << a;
    return {1'b1, 4'(be), 1'b0, 1'b0};
  endfunction

  task automatic chk_regs(input string tag, input logic [6:0] exp);
    chk({tag, ".valid"}, 32'(bus.out_valid),  32'(exp[6]));
    chk({tag, ".be"},    32'(bus.byte_en),    32'(exp[5:2]));
    chk({tag, ".mis"},   32'(bus.misaligned), 32'(exp[1]));
    chk({tag, ".ill"},   32'(bus.illegal),    32'(exp[0]));
    if (bus.misaligned && bus.illegal) chk("mis_and_ill", 32'd1, 32'd0);
  endtask

  task automatic step(input string tag, input bit v, input int f, input int a);
    @(negedge clk);
    chk_regs(tag, pend);
    bus.in_valid = v;
    bus.func3_2  = 2'(f);
    bus.addr_lo  = 2'(a);
    #1;
    chk({tag, ".mode"}, 32'(bus.mode), 32'(mode_ref(f)));
    pend = regs_ref(v, f, a);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.func3_2  = 2'b00;
    bus.addr_lo  = 2'b00;

    // Clock idle and reset held: mode must still follow func3_2.
    #1;
    chk_regs("rst", 7'd0);
    for (int f = 0; f < 4; f++) begin
      bus.func3_2 = 2'(f);
      #0;
      #0;
      chk("sweep.mode", 32'(bus.mode), 32'(mode_ref(f)));
      #5;
    end

    clk_run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    pend = 7'd0;

    for (int a = 0; a < 4; a++) step("byte", 1'b1, 0, a);
    for (int a = 0; a < 4; a++) step("half", 1'b1, 1, a);
    step("word0", 1'b1, 2, 0);
    step("word2", 1'b1, 2, 2);
    step("word1", 1'b1, 2, 1);
    step("word3", 1'b1, 2, 3);
    for (int a = 0; a < 4; a++) step("ill", 1'b1, 3, a);
    step("gate", 1'b0, 2, 1);
    step("gate2", 1'b0, 3, 0);

    for (int i = 0; i < 300; i++)
      step("rand", 1'($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom_range(0, 3));

    // Mid-stream reset between edges with a valid result pending.
    step("pre_rst", 1'b1, 2, 0);
    @(posedge clk);
    #2;
    chk("pre_rst.valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk_regs("midrst", 7'd0);
    bus.func3_2 = 2'b01;
    #1;
    chk("midrst.mode", 32'(bus.mode), 32'd2);
    @(posedge clk);
    #1;
    chk_regs("midrst_edge", 7'd0);
    @(negedge clk);
    rst = 1'b0;
    pend = regs_ref(bus.in_valid, int'(bus.func3_2), int'(bus.addr_lo));

    step("post_rst", 1'b1, 0, 3);
    step("post_rst2", 1'b1, 1, 2);
    @(negedge clk);
    chk_regs("last", pend);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
